// File: rtl/f2f_rx_pkg.sv
// rtl/f2f_rx_pkg.sv - shared constants and types for the F2F receive lane framer
//
// Purpose: lane count, per-lane sync marker, lane byte type and framer state type.
// Ports: none (package).
package f2f_rx_pkg;

    localparam int         LANES     = 5;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [7:0] lane_byte_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/f2f_lane_deskew_framer_if.sv
// rtl/f2f_lane_deskew_framer_if.sv - lane input, aligned word output and status bundle
//
// Purpose: groups the deserializer-side lane bytes/strobes, the aligned word
//          valid/ready stream and the lock/error status into one port.
// Ports (master = framer side):
//   data_i/st_flag      lane bytes and byte strobes into the framer
//   word_o/word_valid   aligned word out, word_ready back from the consumer
//   locked/err_ovf/lock_loss_cnt  status out
interface f2f_lane_deskew_framer_if;
    import f2f_rx_pkg::*;

    logic [LANES*8-1:0] data_i;
    logic [LANES-1:0]   st_flag;
    logic [LANES*8-1:0] word_o;
    logic               word_valid;
    logic               word_ready;
    logic               locked;
    logic               err_ovf;
    logic [7:0]         lock_loss_cnt;

    modport master (
        input  data_i, st_flag, word_ready,
        output word_o, word_valid, locked, err_ovf, lock_loss_cnt
    );

    modport slave (
        output data_i, st_flag, word_ready,
        input  word_o, word_valid, locked, err_ovf, lock_loss_cnt
    );

endinterface

// File: rtl/f2f_lane_fifo.sv
// rtl/f2f_lane_fifo.sv - per-lane synchronous deskew FIFO
//
// Purpose: small show-ahead FIFO absorbing inter-lane skew for one lane.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_push, i_data     write strobe and byte
//   i_pop              read strobe (o_data is the head entry)
//   i_flush            drop all entries (wins over push/pop)
//   o_full, o_empty    occupancy flags
// A push while full is accepted only when the same cycle also pops.
module f2f_lane_fifo
    import f2f_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  lane_byte_t i_data,
    output lane_byte_t o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    lane_byte_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_rd_en;
    logic              w_wr_en;

    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_rd_en = i_pop & ~o_empty;
    // Full-and-popped frees the head slot in the same cycle, so the write may proceed.
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/f2f_lane_deskew_framer.sv
// rtl/f2f_lane_deskew_framer.sv - per-lane sync hunt, deskew and 40-bit word framer
//
// Purpose: hunts for SYNC_BYTE on every lane, buffers post-sync bytes in per-lane
//          FIFOs and emits one lane-aligned word per beat on a valid/ready stream.
// Ports:
//   clk     single clock shared with the deserializers
//   reset   asynchronous active-low reset
//   bus     f2f_lane_deskew_framer_if.master (lane inputs, word stream, status)
module f2f_lane_deskew_framer
    import f2f_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_SKEW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    f2f_lane_deskew_framer_if.master  bus
);

    localparam int            SW       = $clog2(MAX_SKEW + 1);
    localparam logic [SW-1:0] SKEW_LIM = SW'(MAX_SKEW);

    state_t             r_state;
    logic [LANES-1:0]   r_seen;
    logic [SW-1:0]      r_skew;
    logic [LANES*8-1:0] r_word;
    logic               r_word_valid;
    logic               r_err_ovf;
    logic [7:0]         r_lock_loss_cnt;

    logic               w_locked;
    logic [LANES-1:0]   w_sync_hit;
    logic [LANES-1:0]   w_push;
    logic [LANES-1:0]   w_full;
    logic [LANES-1:0]   w_empty;
    logic [LANES-1:0]   w_ovf_lane;
    logic [LANES-1:0]   w_seen_nxt;
    logic [LANES*8-1:0] w_fifo_cat;
    logic               w_pop;
    logic               w_ovf;
    logic               w_partial;
    logic               w_timeout;
    logic               w_go_lock;
    logic               w_flush;

    assign w_locked = (r_state == LOCKED);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_byte_t w_byte;
        lane_byte_t w_head;

        assign w_byte        = bus.data_i[8*n +: 8];
        // In HUNT the marker is consumed, never stored; once LOCKED every byte is data.
        assign w_sync_hit[n] = bus.st_flag[n] & ~r_seen[n] & ~w_locked & (w_byte == SYNC_BYTE);
        assign w_push[n]     = bus.st_flag[n] & (w_locked | r_seen[n]);
        assign w_ovf_lane[n] = w_push[n] & w_full[n] & ~w_pop;
        assign w_fifo_cat[8*n +: 8] = w_head;

        f2f_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (reset),
            .i_push  (w_push[n]),
            .i_pop   (w_pop),
            .i_flush (w_flush),
            .i_data  (w_byte),
            .o_data  (w_head),
            .o_full  (w_full[n]),
            .o_empty (w_empty[n])
        );
    end

    assign w_pop      = w_locked & ~|w_empty & (~r_word_valid | bus.word_ready);
    assign w_ovf      = |w_ovf_lane;
    assign w_seen_nxt = r_seen | w_sync_hit;
    assign w_partial  = (r_seen != '0) & ~&r_seen;
    // Last lane arriving on the very cycle the counter hits the limit still times out.
    assign w_timeout  = ~w_locked & w_partial & (r_skew == SKEW_LIM);
    assign w_go_lock  = ~w_locked & (&w_seen_nxt) & ~w_timeout & ~w_ovf;
    assign w_flush    = w_ovf | w_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
            r_seen  <= '0;
            r_skew  <= '0;
        end else if (w_ovf) begin
            r_state <= HUNT;
            r_seen  <= '0;
            r_skew  <= '0;
        end else if (!w_locked) begin
            if (w_timeout) begin
                r_seen <= '0;
                r_skew <= '0;
            end else begin
                r_seen <= w_seen_nxt;
                if (w_go_lock) begin
                    r_state <= LOCKED;
                    r_skew  <= '0;
                end else if (w_partial) begin
                    r_skew <= r_skew + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else if (w_ovf) begin
            r_word_valid <= 1'b0;
        end else if (w_pop) begin
            r_word       <= w_fifo_cat;
            r_word_valid <= 1'b1;
        end else if (r_word_valid && bus.word_ready) begin
            r_word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_ovf       <= 1'b0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_err_ovf <= w_ovf;
            if (w_ovf && r_lock_loss_cnt != 8'hFF) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
            end
        end
    end

    assign bus.word_o        = r_word;
    assign bus.word_valid    = r_word_valid;
    assign bus.locked        = w_locked;
    assign bus.err_ovf       = r_err_ovf;
    assign bus.lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_f2f_lane_deskew_framer.sv
// tb/tb_f2f_lane_deskew_framer.sv - scoreboard bench for the lane deskew framer
module tb_f2f_lane_deskew_framer;
    import f2f_rx_pkg::*;

    logic clk;
    logic reset;

    f2f_lane_deskew_framer_if bus ();

    f2f_lane_deskew_framer #(.FIFO_DEPTH(4), .MAX_SKEW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] sb[$];

    localparam logic [39:0] SYNC_ALL = {5{8'hA5}};

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [39:0] word_k(input int k);
        logic [39:0] w;
        for (int n = 0; n < 5; n++) w[8*n +: 8] = {4'(n), 4'(k)};
        return w;
    endfunction

    task automatic drive(input logic [39:0] d, input logic [4:0] f);
        @(posedge clk);
        #1;
        bus.data_i  = d;
        bus.st_flag = f;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.data_i  = '0;
        bus.st_flag = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (sb.size() != 0 || bus.word_valid); i++) begin
            drive('0, '0);
            @(negedge clk);
        end
        check(tag, 40'(sb.size()), 40'd0);
    endtask

    // Consumer side: each accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && bus.word_valid && bus.word_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 40'(1), 40'(0));
            end else begin
                check("word", bus.word_o, sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] d;
        logic [4:0]  f;
        int          s[5];

        bus.word_ready = 1'b1;
        do_reset();

        // Reset values
        reset = 1'b0;
        #1;
        check("rst_word_o",   bus.word_o,              40'd0);
        check("rst_valid",    40'(bus.word_valid),     40'd0);
        check("rst_locked",   40'(bus.locked),         40'd0);
        check("rst_err_ovf",  40'(bus.err_ovf),        40'd0);
        check("rst_loss_cnt", 40'(bus.lock_loss_cnt),  40'd0);
        @(negedge clk);
        reset = 1'b1;

        // Zero skew: lock at cycle 1, first word valid at cycle 3
        drive(SYNC_ALL, 5'h1F);
        @(negedge clk);
        check("zs_locked_c0", 40'(bus.locked), 40'd0);
        sb.push_back(40'h0504030201);
        drive(40'h0504030201, 5'h1F);
        @(negedge clk);
        check("zs_locked_c1", 40'(bus.locked), 40'd1);
        drive('0, '0);
        @(negedge clk);
        check("zs_valid_c2", 40'(bus.word_valid), 40'd0);
        drive('0, '0);
        @(negedge clk);
        check("zs_valid_c3", 40'(bus.word_valid), 40'd1);
        check("zs_word_c3",  bus.word_o, 40'h0504030201);
        drain("zs_drain");

        // Skew 3: lane n syncs at s[n], then sends its own bytes k = 0..5
        do_reset();
        s = '{0, 1, 2, 2, 3};
        for (int k = 0; k < 6; k++) sb.push_back(word_k(k));
        for (int c = 0; c < 10; c++) begin
            d = '0;
            f = '0;
            for (int n = 0; n < 5; n++) begin
                if (c == s[n]) begin
                    d[8*n +: 8] = 8'hA5;
                    f[n]        = 1'b1;
                end else if (c > s[n] && (c - s[n] - 1) < 6) begin
                    d[8*n +: 8] = {4'(n), 4'(c - s[n] - 1)};
                    f[n]        = 1'b1;
                end
            end
            drive(d, f);
            @(negedge clk);
            if (c == 3) check("sk_locked_c3", 40'(bus.locked), 40'd0);
            if (c == 4) check("sk_locked_c4", 40'(bus.locked), 40'd1);
        end
        drain("sk_drain");
        check("sk_err_cnt", 40'(bus.lock_loss_cnt), 40'd0);

        // Skew timeout: lane 4 silent, seen clears, no word and no overflow
        do_reset();
        drive(SYNC_ALL, 5'h0F);
        for (int c = 1; c <= 12; c++) begin
            drive('0, '0);
            @(negedge clk);
            check("to_locked", 40'(bus.locked), 40'd0);
            check("to_err_ovf", 40'(bus.err_ovf), 40'd0);
            check("to_valid", 40'(bus.word_valid), 40'd0);
        end
        drive(SYNC_ALL, 5'h10);
        repeat (3) drive('0, '0);
        @(negedge clk);
        check("to_seen_cleared", 40'(bus.locked), 40'd0);
        drive(SYNC_ALL, 5'h0F);
        drive('0, '0);
        @(negedge clk);
        check("to_relock", 40'(bus.locked), 40'd1);
        sb.push_back(word_k(7));
        drive(word_k(7), 5'h1F);
        drain("to_drain");

        // Backpressure: sixth unconsumed strobe overflows
        do_reset();
        bus.word_ready = 1'b0;
        drive(SYNC_ALL, 5'h1F);
        for (int k = 0; k < 6; k++) drive(word_k(k), 5'h1F);
        @(negedge clk);
        check("bp_hold_word",  bus.word_o, word_k(0));
        check("bp_hold_valid", 40'(bus.word_valid), 40'd1);
        check("bp_no_err_yet", 40'(bus.err_ovf), 40'd0);
        drive('0, '0);
        @(negedge clk);
        check("bp_err_ovf",   40'(bus.err_ovf),       40'd1);
        check("bp_loss_cnt",  40'(bus.lock_loss_cnt), 40'd1);
        check("bp_unlocked",  40'(bus.locked),        40'd0);
        check("bp_valid_low", 40'(bus.word_valid),    40'd0);
        drive('0, '0);
        @(negedge clk);
        check("bp_err_pulse", 40'(bus.err_ovf), 40'd0);

        // Full FIFOs plus simultaneous pop: push into full is legal, words stream in order
        do_reset();
        bus.word_ready = 1'b0;
        for (int k = 0; k < 10; k++) sb.push_back(word_k(k));
        drive(SYNC_ALL, 5'h1F);
        for (int k = 0; k < 5; k++) drive(word_k(k), 5'h1F);
        for (int k = 5; k < 10; k++) begin
            drive(word_k(k), 5'h1F);
            bus.word_ready = 1'b1;
            @(negedge clk);
            check("fp_err_ovf", 40'(bus.err_ovf), 40'd0);
        end
        drain("fp_drain");
        check("fp_loss_cnt", 40'(bus.lock_loss_cnt), 40'd0);
        check("fp_locked",   40'(bus.locked),        40'd1);

        // Mid-stream reset: outputs clear immediately, relock needs a sync
        bus.word_ready = 1'b0;
        drive(word_k(1), 5'h1F);
        drive(word_k(2), 5'h1F);
        drive(word_k(3), 5'h1F);
        #2;
        check("mr_pre_valid", 40'(bus.word_valid), 40'd1);
        reset = 1'b0;
        #1;
        check("mr_word_o", bus.word_o,              40'd0);
        check("mr_valid",  40'(bus.word_valid),     40'd0);
        check("mr_locked", 40'(bus.locked),         40'd0);
        check("mr_err",    40'(bus.err_ovf),        40'd0);
        check("mr_cnt",    40'(bus.lock_loss_cnt),  40'd0);
        sb.delete();
        @(negedge clk);
        reset          = 1'b1;
        bus.word_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(word_k(k), 5'h1F);
            @(negedge clk);
            check("mr_no_lock", 40'(bus.locked), 40'd0);
        end
        drive('0, '0);
        @(negedge clk);
        check("mr_no_word", 40'(bus.word_valid), 40'd0);
        drive(SYNC_ALL, 5'h1F);
        drive('0, '0);
        @(negedge clk);
        check("mr_relock", 40'(bus.locked), 40'd1);
        drain("mr_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/f2f_lane_deskew_framer.md
# f2f_lane_deskew_framer

Downstream of the 5-lane LVDS deserializer in the F2F receive path. Consumes the per-lane 8-bit words and per-lane `st_flag` byte strobes, hunts for a per-lane sync byte, removes inter-lane skew with small per-lane FIFOs, and emits one lane-aligned 40-bit word per beat over a valid/ready handshake. Downstream consumers are the F2F RX frame logic and AXI glue.

## Interface
- `LANES`, 5, number of serial lanes
- `FIFO_DEPTH`, 4, entries per lane deskew FIFO (power of two)
- `SYNC_BYTE`, 8'hA5, per-lane alignment marker
- `MAX_SKEW`, 8, cycles allowed between first and last lane sync detection
- `clk`  in  1  single clock, shared with the deserializers
- `reset`  in  1  asynchronous, active-low reset
- `data_i`  in  LANES*8  lane n byte on bits [8n+7:8n]
- `st_flag`  in  LANES  lane n byte strobe, one cycle per new byte
- `word_o`  out  LANES*8  aligned word, lane n on bits [8n+7:8n]
- `word_valid`  out  1  `word_o` holds an unconsumed word
- `word_ready`  in  1  consumer accepts the word when high with `word_valid`
- `locked`  out  1  all lanes aligned
- `err_ovf`  out  1  one-cycle pulse on loss of lock from FIFO overflow
- `lock_loss_cnt`  out  8  saturating count of lock losses

## Operation
- Two states: HUNT (reset state) and LOCKED. `locked` = (state == LOCKED).
- HUNT: a strobed byte on an unseen lane is discarded unless it equals `SYNC_BYTE`. The sync byte sets `seen[n]` and is not stored. Strobed bytes on seen lanes are pushed into that lane's FIFO.
- The skew counter starts at 0 on the cycle the first lane becomes seen and increments each cycle while some but not all lanes are seen.
- All lanes seen (including several on the same cycle) with counter < `MAX_SKEW` -> LOCKED.
- Counter reaches `MAX_SKEW` first -> clear `seen`, flush all FIFOs, stay in HUNT.
- LOCKED: every strobed byte is pushed, including bytes equal to `SYNC_BYTE`. There is no in-band resync.
- Pop: when every FIFO is non-empty and the output register is empty or being consumed this cycle (`word_valid & word_ready`), pop one entry per lane and load `word_o`. Pops occur only in LOCKED.
- Overflow: a push into a FIFO that is full and not popped that cycle triggers the following, in both states:
  - `err_ovf` pulses for one cycle.
  - `lock_loss_cnt` increments, saturating at 255.
  - All FIFOs flush, `seen` clears, `word_valid` drops, and the state goes to HUNT.
- A push into a full FIFO on a cycle it is also popped is legal and is not an overflow.
- `word_o` holds its value while `word_valid` is high and `word_ready` is low.

## Timing
- Reset values: `word_o` = 0, `word_valid` = 0, `locked` = 0, `err_ovf` = 0, `lock_loss_cnt` = 0. FIFOs are empty, `seen` = 0, skew counter = 0.
- Reset assertion mid-operation clears everything immediately, asynchronously. Release is synchronous to `clk`.
- HUNT -> LOCKED: `locked` rises the cycle after the last lane's sync strobe.
- Latency: the last lane's byte is strobed at cycle t, FIFO write lands at the end of t, pop happens in t+1, and `word_valid` is high in t+2.
- Throughput is one word per cycle when all lanes strobe every cycle and `word_ready` = 1.
- Backpressure is absorbed only by FIFO depth. Overflow occurs after `FIFO_DEPTH` + 1 unpopped strobes on one lane.

## Structure
- Package `f2f_rx_pkg`: `LANES`, `SYNC_BYTE`, the `state_t` enum {HUNT, LOCKED}, and the lane byte type.
- Sub-module `f2f_lane_fifo`, one instance per lane (generate loop): synchronous FIFO with push, pop, flush, full, empty, and a same-cycle push+pop-when-full pass.
- The top level holds the FSM, skew counter, output register, and error counter.

## Test plan
- Zero skew: all lanes strobe 0xA5 on cycle 0, then bytes 0x01..0x05 per lane on cycle 1 -> `locked` = 1 at cycle 1, `word_o` = 0x0504030201 valid at cycle 3.
- Skew 3: lane 0 sees sync at cycle 0, lane 4 at cycle 3, then lane-indexed data follows -> lock, and the first word pairs the first post-sync byte of every lane.
- Skew timeout: lanes 0–3 sync, lane 4 silent for 8 cycles -> stays in HUNT, `seen` cleared, no word, no `err_ovf`.
- Backpressure: locked, `word_ready` = 0, all lanes strobe 6 bytes -> `word_o` holds the first word, the 6th strobe overflows, `err_ovf` pulses, `lock_loss_cnt` = 1, `locked` = 0, `word_valid` = 0.
- Full plus simultaneous pop: each FIFO full, `word_ready` = 1 while all lanes strobe -> no overflow, words stream in order.
- Mid-stream reset: assert `reset` low during LOCKED traffic -> all outputs zero that cycle; after release, a sync is needed to relock.
